// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: decodes the RV32/RV64 immediate for the incoming
// instruction and carries it with PC/instruction through a 2-entry skid buffer.
module imm_decode_stage #(
  parameter int XLEN        = 32,
  parameter bit ENABLE_ZIMM = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_kind,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_LOAD_FP   = 7'b0000111;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_STORE_FP  = 7'b0100111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    KIND_NONE = 3'd0,
    KIND_I    = 3'd1,
    KIND_S    = 3'd2,
    KIND_B    = 3'd3,
    KIND_U    = 3'd4,
    KIND_J    = 3'd5,
    KIND_Z    = 3'd6
  } imm_kind_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      kind;
    logic            illegal;
  } entry_t;

  entry_t dec_s;
  entry_t m_r;
  entry_t k_r;
  logic   m_valid_r;
  logic   k_valid_r;
  logic   accept_s;
  logic   drain_s;

  // Decode the incoming instruction into a buffer entry
  always_comb begin
    dec_s         = '0;
    dec_s.inst    = in_inst;
    dec_s.pc      = in_pc;
    dec_s.illegal = (in_inst[1:0] != 2'b11);
    if (dec_s.illegal) begin
      dec_s.kind = KIND_NONE;
      dec_s.imm  = '0;
    end else begin
      case (in_inst[6:0])
        OP_LOAD, OP_LOAD_FP, OP_OP_IMM, OP_JALR: begin
          dec_s.kind = KIND_I;
          dec_s.imm  = XLEN'($signed(in_inst[31:20]));
        end
        OP_OP_IMM_32: begin
          if (XLEN == 64) begin
            dec_s.kind = KIND_I;
            dec_s.imm  = XLEN'($signed(in_inst[31:20]));
          end else begin
            dec_s.kind = KIND_NONE;
            dec_s.imm  = '0;
          end
        end
        OP_STORE, OP_STORE_FP: begin
          dec_s.kind = KIND_S;
          dec_s.imm  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
        end
        OP_BRANCH: begin
          dec_s.kind = KIND_B;
          dec_s.imm  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                      in_inst[11:8], 1'b0}));
        end
        OP_LUI, OP_AUIPC: begin
          dec_s.kind = KIND_U;
          dec_s.imm  = XLEN'($signed({in_inst[31:12], 12'h000}));
        end
        OP_JAL: begin
          dec_s.kind = KIND_J;
          dec_s.imm  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                      in_inst[30:21], 1'b0}));
        end
        OP_SYSTEM: begin
          // funct3[2] selects the CSR-immediate forms; rs1 field carries the zimm
          if (ENABLE_ZIMM && in_inst[14]) begin
            dec_s.kind = KIND_Z;
            dec_s.imm  = XLEN'(in_inst[19:15]);
          end else begin
            dec_s.kind = KIND_NONE;
            dec_s.imm  = '0;
          end
        end
        default: begin
          dec_s.kind = KIND_NONE;
          dec_s.imm  = '0;
        end
      endcase
    end
  end

  // in_ready depends only on the skid register, so out_ready never reaches it combinationally
  assign in_ready = !k_valid_r;
  assign accept_s = in_valid && !k_valid_r && !flush;
  assign drain_s  = m_valid_r && out_ready;

  // Main/skid register update; reset beats flush beats handshakes
  always_ff @(posedge clock) begin
    if (reset) begin
      m_valid_r <= 1'b0;
      k_valid_r <= 1'b0;
      m_r       <= '0;
      k_r       <= '0;
    end else if (flush) begin
      m_valid_r <= 1'b0;
      k_valid_r <= 1'b0;
    end else if (drain_s) begin
      if (k_valid_r) begin
        m_r       <= k_r;
        k_valid_r <= accept_s;
        if (accept_s) begin
          k_r <= dec_s;
        end
      end else begin
        m_valid_r <= accept_s;
        if (accept_s) begin
          m_r <= dec_s;
        end
      end
    end else if (accept_s) begin
      if (m_valid_r) begin
        k_r       <= dec_s;
        k_valid_r <= 1'b1;
      end else begin
        m_r       <= dec_s;
        m_valid_r <= 1'b1;
      end
    end
  end

  assign out_valid   = m_valid_r;
  assign out_inst    = m_r.inst;
  assign out_pc      = m_r.pc;
  assign out_imm     = m_r.imm;
  assign out_kind    = m_r.kind;
  assign out_illegal = m_r.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: three configurations driven in lockstep, checked against
// an arithmetic immediate model and a FIFO scoreboard of accepted entries.
module tb_imm_decode_stage;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_inst, a_out_pc, a_out_imm;
  logic [2:0]  a_out_kind;
  logic b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_inst;
  logic [63:0] b_out_pc, b_out_imm;
  logic [2:0]  b_out_kind;
  logic c_in_ready, c_out_valid, c_out_illegal;
  logic [31:0] c_out_inst, c_out_pc, c_out_imm;
  logic [2:0]  c_out_kind;

  always #5 clock = ~clock;

  imm_decode_stage #(.XLEN(32), .ENABLE_ZIMM(1'b1)) dut_a (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_inst(a_out_inst), .out_pc(a_out_pc), .out_imm(a_out_imm), .out_kind(a_out_kind),
    .out_illegal(a_out_illegal));

  imm_decode_stage #(.XLEN(64), .ENABLE_ZIMM(1'b1)) dut_b (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_inst(b_out_inst), .out_pc(b_out_pc), .out_imm(b_out_imm), .out_kind(b_out_kind),
    .out_illegal(b_out_illegal));

  imm_decode_stage #(.XLEN(32), .ENABLE_ZIMM(1'b0)) dut_c (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_inst(c_out_inst), .out_pc(c_out_pc), .out_imm(c_out_imm), .out_kind(c_out_kind),
    .out_illegal(c_out_illegal));

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [63:0] got[$];
  logic [63:0] pcs[4] = '{64'h0, 64'h4, 64'h8, 64'hC};
  logic [6:0]  ops[12] = '{7'h03, 7'h07, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h27, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h73};
  int          checks = 0;
  int          failures = 0;
  bit          last_acc;
  int          idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Immediate value computed from the ISA bit positions with plain arithmetic
  function automatic void ref_decode(input logic [31:0] inst, input int xlen, input bit zimm,
                                     output logic [2:0] kind, output logic [63:0] imm);
    longint v;
    v = 0;
    kind = 3'd0;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        7'h03, 7'h07, 7'h13, 7'h67: begin
          kind = 3'd1;
          v = longint'(inst[31:20]) - (inst[31] ? 4096 : 0);
        end
        7'h1B: if (xlen == 64) begin
          kind = 3'd1;
          v = longint'(inst[31:20]) - (inst[31] ? 4096 : 0);
        end
        7'h23, 7'h27: begin
          kind = 3'd2;
          v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]) - (inst[31] ? 4096 : 0);
        end
        7'h63: begin
          kind = 3'd3;
          v = longint'(inst[11:8]) * 2 + longint'(inst[30:25]) * 32
            + longint'(inst[7]) * 2048 - (inst[31] ? 4096 : 0);
        end
        7'h37, 7'h17: begin
          kind = 3'd4;
          v = longint'(inst[31:12]) * 4096 - (inst[31] ? 64'sh1_0000_0000 : 64'sh0);
        end
        7'h6F: begin
          kind = 3'd5;
          v = longint'(inst[30:21]) * 2 + longint'(inst[20]) * 2048
            + longint'(inst[19:12]) * 4096 - (inst[31] ? 64'sh10_0000 : 64'sh0);
        end
        7'h73: if (zimm && inst[14]) begin
          kind = 3'd6;
          v = longint'(inst[19:15]);
        end
        default: ;
      endcase
    end
    imm = v;
    if (xlen == 32) imm[63:32] = 32'h0;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int r;
    w = $urandom();
    r = $urandom_range(0, 15);
    if (r < 12) w[6:0] = ops[r];
    else if (r == 12) w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  task automatic check_model();
    logic [2:0]  k;
    logic [63:0] im;
    ent_t        e;
    chk("a_in_ready", a_in_ready, q.size() < 2);
    chk("b_in_ready", b_in_ready, q.size() < 2);
    chk("c_in_ready", c_in_ready, q.size() < 2);
    chk("a_out_valid", a_out_valid, q.size() > 0);
    chk("b_out_valid", b_out_valid, q.size() > 0);
    chk("c_out_valid", c_out_valid, q.size() > 0);
    if (q.size() > 0) begin
      e = q[0];
      chk("a_inst", a_out_inst, e.inst);
      chk("b_inst", b_out_inst, e.inst);
      chk("a_pc", a_out_pc, e.pc[31:0]);
      chk("b_pc", b_out_pc, e.pc);
      chk("c_pc", c_out_pc, e.pc[31:0]);
      chk("a_illegal", a_out_illegal, e.inst[1:0] != 2'b11);
      chk("b_illegal", b_out_illegal, e.inst[1:0] != 2'b11);
      ref_decode(e.inst, 32, 1'b1, k, im);
      chk("a_kind", a_out_kind, k);
      chk("a_imm", a_out_imm, im[31:0]);
      ref_decode(e.inst, 64, 1'b1, k, im);
      chk("b_kind", b_out_kind, k);
      chk("b_imm", b_out_imm, im);
      ref_decode(e.inst, 32, 1'b0, k, im);
      chk("c_kind", c_out_kind, k);
      chk("c_imm", c_out_imm, im[31:0]);
    end
  endtask

  task automatic step();
    bit   acc, drn;
    ent_t e;
    acc = in_valid && (q.size() < 2) && !flush && !reset;
    drn = (q.size() > 0) && out_ready && !reset;
    if (drn) got.push_back({32'h0, a_out_pc});
    @(posedge clock);
    #1;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (drn) q.delete(0);
      if (acc) begin
        e.inst = in_inst;
        e.pc   = in_pc;
        q.push_back(e);
      end
    end
    last_acc = acc;
    check_model();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_a_imm"}, a_out_imm, 64'h0);
    chk({tag, "_a_pc"}, a_out_pc, 64'h0);
    chk({tag, "_a_inst"}, a_out_inst, 64'h0);
    chk({tag, "_a_kind"}, a_out_kind, 64'h0);
    chk({tag, "_a_illegal"}, a_out_illegal, 64'h0);
    chk({tag, "_b_imm"}, b_out_imm, 64'h0);
    chk({tag, "_b_pc"}, b_out_pc, 64'h0);
    chk({tag, "_c_imm"}, c_out_imm, 64'h0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 64'h0;
    step();
    step();
    check_zero_outputs("reset");

    // Directed decode vectors
    reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    in_inst = 32'hFFF0_0093; in_pc = 64'h100;
    step();
    chk("addi_kind", a_out_kind, 64'd1);
    chk("addi_imm32", a_out_imm, 64'hFFFF_FFFF);
    chk("addi_imm64", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    in_inst = 32'h8000_00B7; in_pc = 64'h104;
    step();
    chk("lui_kind", b_out_kind, 64'd4);
    chk("lui_imm64", b_out_imm, 64'hFFFF_FFFF_8000_0000);
    in_inst = 32'hFE00_0EE3; in_pc = 64'h108;
    step();
    chk("beq_kind", b_out_kind, 64'd3);
    chk("beq_imm64", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    in_inst = 32'h3002_D073; in_pc = 64'h10C;
    step();
    chk("csrrwi_kind_z", a_out_kind, 64'd6);
    chk("csrrwi_imm_z", a_out_imm, 64'd5);
    chk("csrrwi_kind_noz", c_out_kind, 64'd0);
    chk("csrrwi_imm_noz", c_out_imm, 64'd0);
    in_inst = 32'h0000_0001; in_pc = 64'h110;
    step();
    chk("illegal_flag", a_out_illegal, 64'd1);
    chk("illegal_kind", b_out_kind, 64'd0);
    chk("illegal_imm", b_out_imm, 64'd0);

    // Backpressure: two accepts fill the buffer, head held, then in-order drain
    in_valid = 1'b0;
    step();
    step();
    got.delete();
    idx = 0;
    in_valid = 1'b1; out_ready = 1'b1; in_pc = pcs[0]; in_inst = rand_inst();
    step();
    if (last_acc) idx++;
    out_ready = 1'b0; in_pc = pcs[idx]; in_inst = rand_inst();
    step();
    if (last_acc) idx++;
    chk("bp_accepts", idx, 64'd2);
    chk("bp_in_ready", a_in_ready, 64'd0);
    for (int i = 0; i < 3; i++) begin
      in_pc = pcs[2]; in_inst = rand_inst();
      step();
      chk("bp_hold_pc", a_out_pc, 64'h0);
      chk("bp_hold_valid", a_out_valid, 64'd1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && idx < 4; i++) begin
      in_pc = pcs[idx]; in_inst = rand_inst();
      step();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    chk("bp_all_accepted", idx, 64'd4);
    chk("bp_drain_count", got.size(), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("bp_order", got[i], pcs[i]);
    end

    // Flush with both entries full and an input offered in the flush cycle
    in_valid = 1'b1; out_ready = 1'b0;
    in_inst = rand_inst(); in_pc = 64'h400;
    step();
    in_inst = rand_inst(); in_pc = 64'h404;
    step();
    chk("fl_full", a_in_ready, 64'd0);
    flush = 1'b1; in_inst = 32'h0000_0013; in_pc = 64'hDEAD_0000;
    step();
    chk("fl_out_valid", a_out_valid, 64'd0);
    chk("fl_in_ready", a_in_ready, 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_ghost", b_out_valid, 64'd0);
    end

    // Reset mid-stream, then 1-cycle latency on the next accept
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_inst = rand_inst(); in_pc = 64'h500 + 64'(4 * i);
      step();
    end
    reset = 1'b1;
    step();
    check_zero_outputs("midreset");
    chk("midreset_valid", a_out_valid, 64'd0);
    chk("midreset_in_ready", a_in_ready, 64'd1);
    reset = 1'b0; in_inst = 32'hFFF0_0093; in_pc = 64'h600;
    step();
    chk("postreset_valid", a_out_valid, 64'd1);
    chk("postreset_pc", b_out_pc, 64'h600);
    in_valid = 1'b0;
    step();

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 127) == 0);
      in_inst   = rand_inst();
      in_pc     = {$urandom(), $urandom()};
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
